// File: rtl/imem_loader.sv
// Instruction-memory boot loader.
// Receives a byte stream made of a 4-byte little-endian word count N, followed by N
// little-endian 32-bit words. It writes those words to IMEM addresses 0..N-1 and
// holds the core in reset until the whole image has been written.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    // One extra bit, so that N == DEPTH_WORDS can be counted without wrapping
    localparam int unsigned CNT_W     = ADDR_W + 1;
    // The idle counter only has to reach TIMEOUT_CYC-1 before the terminal compare
    localparam int unsigned IDLE_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned IDLE_LAST = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
    localparam logic [31:0] DEPTH_N   = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t             r_state;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_n;
    logic [31:0]        r_asm;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [IDLE_W-1:0]  r_idle;

    logic               r_s_ready;
    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic               r_core_rst;
    logic               r_done;
    logic               r_err;

    logic               w_xfer;
    logic [31:0]        w_hdr_word;
    logic [31:0]        w_data_word;
    logic               w_last_word;
    logic               w_idle_en;
    logic               w_timeout;

    // Handshake and byte-assembly helpers; bytes are shifted in at the top, so the first byte ends up at the LSB
    assign w_xfer      = s_valid && r_s_ready;
    assign w_hdr_word  = {s_data, r_n[31:8]};
    assign w_data_word = {s_data, r_asm[31:8]};
    assign w_last_word = ((32'(r_word_cnt) + 32'd1) == r_n);

    // Idle cycles count only while a header or image is partially received
    assign w_idle_en   = (TIMEOUT_CYC != 0) && !w_xfer &&
                         ((r_state == ST_DATA) ||
                          ((r_state == ST_HDR) && (r_byte_cnt != 2'd0)));
    assign w_timeout   = w_idle_en && (r_idle == IDLE_W'(IDLE_LAST));

    // Loader FSM; outputs are registered together with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HDR;
            r_byte_cnt   <= 2'd0;
            r_n          <= 32'd0;
            r_asm        <= 32'd0;
            r_word_cnt   <= '0;
            r_idle       <= '0;
            r_s_ready    <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;

            if (w_xfer) begin
                r_idle <= '0;
            end else if (w_idle_en) begin
                r_idle <= r_idle + IDLE_W'(1);
            end

            case (r_state)
                ST_HDR: begin
                    if (w_xfer) begin
                        r_n        <= w_hdr_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_hdr_word == 32'd0) begin
                                r_state    <= ST_DONE;
                                r_s_ready  <= 1'b0;
                                r_core_rst <= 1'b0;
                                r_done     <= 1'b1;
                            end else if (w_hdr_word > DEPTH_N) begin
                                r_state    <= ST_ERR;
                                r_s_ready  <= 1'b0;
                                r_err      <= 1'b1;
                            end else begin
                                r_state    <= ST_DATA;
                                r_word_cnt <= '0;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state   <= ST_ERR;
                        r_s_ready <= 1'b0;
                        r_err     <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_xfer) begin
                        r_asm      <= w_data_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state      <= ST_WRITE;
                            r_s_ready    <= 1'b0;
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= ADDR_W'(r_word_cnt);
                            r_imem_wdata <= w_data_word;
                        end
                    end else if (w_timeout) begin
                        r_state   <= ST_ERR;
                        r_s_ready <= 1'b0;
                        r_err     <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                    if (w_last_word) begin
                        r_state    <= ST_DONE;
                        r_core_rst <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= ST_DATA;
                        r_s_ready  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_DONE;
                end

                ST_ERR: begin
                    r_state <= ST_ERR;
                end

                default: begin
                    r_state    <= ST_ERR;
                    r_s_ready  <= 1'b0;
                    r_core_rst <= 1'b1;
                    r_done     <= 1'b0;
                    r_err      <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign core_rst   = r_core_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal image, empty image, oversize header,
// stream gaps, reset aborts, and idle timeouts.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned DEPTH = 2048;
    localparam int unsigned TO    = 16;
    localparam int unsigned AW    = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          done;
    logic          err;

    int checks = 0;
    int fails  = 0;

    logic [AW-1:0] wr_addr_q [$];
    logic [31:0]   wr_data_q [$];

    logic [7:0] img [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h50, 8'h00,
                             8'h13, 8'h01, 8'hA0, 8'h00};

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .TIMEOUT_CYC (TO),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Log every IMEM write strobe
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) begin
            s_valid = 1'b0; s_data = 8'($urandom);
            @(posedge clk); #1;
        end
        guard = 0;
        while (s_ready !== 1'b1 && guard < 50) begin
            s_valid = 1'b0; s_data = 8'($urandom);
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) begin
            checks++; fails++;
            $display("FAIL send_byte: s_ready stuck low, got %b expected 1", s_ready);
        end
        s_valid = 1'b1; s_data = b;
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = 8'hC3;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h77;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        checks++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", imem_we); end
        checks++; if (core_rst !== 1'b1) begin fails++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        // Idling before the first header byte must never time out
        tick(40);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL hdr_idle_err: got %b expected 0", err); end
        checks++; if (s_ready !== 1'b1) begin fails++; $display("FAIL hdr_idle_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_basic();
        int base;
        do_reset();
        base = wr_addr_q.size();
        for (int i = 0; i < 12; i++) send_byte(img[i], 0);
        checks++; if (imem_we !== 1'b1) begin fails++; $display("FAIL basic_we2: got %b expected 1", imem_we); end
        checks++; if (imem_addr !== 11'd1) begin fails++; $display("FAIL basic_addr2: got %h expected 1", imem_addr); end
        checks++; if (imem_wdata !== 32'h00A00113) begin fails++; $display("FAIL basic_data2: got %h expected 00a00113", imem_wdata); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_early: got %b expected 0", done); end
        tick(1);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done: got %b expected 1", done); end
        checks++; if (core_rst !== 1'b0) begin fails++; $display("FAIL basic_core_rst: got %b expected 0", core_rst); end
        checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL basic_ready: got %b expected 0", s_ready); end
        checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL basic_we_off: got %b expected 0", imem_we); end
        checks++;
        if (wr_addr_q.size() - base !== 2) begin
            fails++; $display("FAIL basic_nwrites: got %0d expected 2", wr_addr_q.size() - base);
        end else begin
            checks++; if (wr_addr_q[base] !== 11'd0 || wr_data_q[base] !== 32'h00500093) begin
                fails++; $display("FAIL basic_w0: got %h/%h expected 0/00500093", wr_addr_q[base], wr_data_q[base]); end
            checks++; if (wr_addr_q[base+1] !== 11'd1 || wr_data_q[base+1] !== 32'h00A00113) begin
                fails++; $display("FAIL basic_w1: got %h/%h expected 1/00a00113", wr_addr_q[base+1], wr_data_q[base+1]); end
        end
    endtask

    task automatic test_zero();
        int base;
        do_reset();
        base = wr_addr_q.size();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (core_rst !== 1'b0) begin fails++; $display("FAIL zero_core_rst: got %b expected 0", core_rst); end
        checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL zero_ready: got %b expected 0", s_ready); end
        // Bytes offered in DONE are ignored
        s_valid = 1'b1; s_data = 8'hAA;
        tick(8);
        s_valid = 1'b0;
        checks++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL zero_hold: got done=%b err=%b expected 1/0", done, err); end
        checks++; if (wr_addr_q.size() != base) begin fails++; $display("FAIL zero_nwrites: got %0d expected 0", wr_addr_q.size() - base); end
    endtask

    task automatic test_oversize();
        int base;
        do_reset();
        base = wr_addr_q.size();
        send_byte(8'h01, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL over_err: got %b expected 1", err); end
        checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL over_ready: got %b expected 0", s_ready); end
        checks++; if (core_rst !== 1'b1) begin fails++; $display("FAIL over_core_rst: got %b expected 1", core_rst); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL over_done: got %b expected 0", done); end
        s_valid = 1'b1; s_data = 8'h55;
        tick(8);
        s_valid = 1'b0;
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL over_sticky: got %b expected 1", err); end
        checks++; if (wr_addr_q.size() != base) begin fails++; $display("FAIL over_nwrites: got %0d expected 0", wr_addr_q.size() - base); end
        // N == DEPTH_WORDS is legal: it enters DATA and accepts the first word
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++; if (err !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL depth_ok: got err=%b ready=%b expected 0/1", err, s_ready); end
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 11'd0 || imem_wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL depth_w0: got we=%b %h/%h expected 1 0/deadbeef", imem_we, imem_addr, imem_wdata); end
    endtask

    task automatic test_gaps();
        int base;
        do_reset();
        base = wr_addr_q.size();
        for (int i = 0; i < 12; i++) send_byte(img[i], int'($urandom_range(0, 5)));
        checks++; if (imem_we !== 1'b1 || imem_addr !== 11'd1 || imem_wdata !== 32'h00A00113) begin
            fails++; $display("FAIL gaps_last: got we=%b %h/%h expected 1 1/00a00113", imem_we, imem_addr, imem_wdata); end
        tick(1);
        checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin fails++; $display("FAIL gaps_done: got done=%b core_rst=%b expected 1/0", done, core_rst); end
        checks++;
        if (wr_addr_q.size() - base !== 2) begin
            fails++; $display("FAIL gaps_nwrites: got %0d expected 2", wr_addr_q.size() - base);
        end else begin
            checks++; if (wr_addr_q[base] !== 11'd0 || wr_data_q[base] !== 32'h00500093) begin
                fails++; $display("FAIL gaps_w0: got %h/%h expected 0/00500093", wr_addr_q[base], wr_data_q[base]); end
        end
    endtask

    task automatic test_rst_mid();
        int base;
        do_reset();
        base = wr_addr_q.size();
        // Header plus six data bytes: word 0 complete, word 1 half assembled
        for (int i = 0; i < 10; i++) send_byte(img[i], 0);
        checks++; if (wr_addr_q.size() - base !== 1) begin fails++; $display("FAIL mid_pre_writes: got %0d expected 1", wr_addr_q.size() - base); end
        // Reset coincides with an offered byte; reset must win
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        checks++; if (s_ready !== 1'b1 || core_rst !== 1'b1 || imem_we !== 1'b0) begin
            fails++; $display("FAIL mid_after_rst: got ready=%b core_rst=%b we=%b expected 1/1/0", s_ready, core_rst, imem_we); end
        tick(3);
        checks++; if (wr_addr_q.size() - base !== 1) begin fails++; $display("FAIL mid_no_write: got %0d expected 1", wr_addr_q.size() - base); end
        for (int i = 0; i < 12; i++) send_byte(img[i], 0);
        tick(1);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL mid_done: got done=%b err=%b expected 1/0", done, err); end
        checks++;
        if (wr_addr_q.size() - base !== 3) begin
            fails++; $display("FAIL mid_nwrites: got %0d expected 3", wr_addr_q.size() - base);
        end else begin
            checks++; if (wr_addr_q[base+1] !== 11'd0 || wr_data_q[base+1] !== 32'h00500093) begin
                fails++; $display("FAIL mid_w0: got %h/%h expected 0/00500093", wr_addr_q[base+1], wr_data_q[base+1]); end
            checks++; if (wr_addr_q[base+2] !== 11'd1 || wr_data_q[base+2] !== 32'h00A00113) begin
                fails++; $display("FAIL mid_w1: got %h/%h expected 1/00a00113", wr_addr_q[base+2], wr_data_q[base+2]); end
        end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = wr_addr_q.size();
        for (int i = 0; i < 5; i++) send_byte(img[i], 0);
        tick(15);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL to_early: got %b expected 0 after 15 idle", err); end
        tick(1);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL to_err: got %b expected 1 after 16 idle", err); end
        checks++; if (s_ready !== 1'b0 || core_rst !== 1'b1) begin fails++; $display("FAIL to_outs: got ready=%b core_rst=%b expected 0/1", s_ready, core_rst); end
        checks++; if (wr_addr_q.size() != base) begin fails++; $display("FAIL to_nwrites: got %0d expected 0", wr_addr_q.size() - base); end
        // A stall after the first header byte also times out
        do_reset();
        send_byte(8'h02, 0);
        tick(15);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL to_hdr_early: got %b expected 0", err); end
        tick(1);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL to_hdr_err: got %b expected 1", err); end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        test_reset();
        test_basic();
        test_zero();
        test_oversize();
        test_gaps();
        test_rst_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 2048, instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, max idle cycles between bytes mid-image; 0 disables the timeout.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH_WORDS), word-address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  byte-stream source has a byte.
REQ-007 SHALL have port s_data  input  8  byte-stream payload.
REQ-008 SHALL have port s_ready  output  1  loader accepts a byte; transfer occurs when s_valid && s_ready.
REQ-009 SHALL have port imem_we  output  1  one-cycle IMEM word write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_W  IMEM word index.
REQ-011 SHALL have port imem_wdata  output  32  IMEM write word.
REQ-012 SHALL have port core_rst  output  1  active-high reset to the single-cycle core, held until the image is loaded.
REQ-013 SHALL have port done  output  1  image loaded; core released.
REQ-014 SHALL have port err  output  1  sticky load failure.

Function
REQ-015 SHALL accept the stream format: 4-byte little-endian word count N, followed by 4*N bytes forming N little-endian 32-bit words written to IMEM word addresses 0..N-1.
REQ-016 SHALL implement states HDR, DATA, WRITE, DONE, ERR.
REQ-017 SHALL drive s_ready=1 in HDR and DATA only and 0 in WRITE, DONE and ERR.
REQ-018 HDR SHALL collect 4 bytes into N; after the 4th accepted byte: N==0 -> DONE, N>DEPTH_WORDS -> ERR, otherwise -> DATA with word counter 0.
REQ-019 DATA SHALL assemble bytes LSB-first; the cycle after the 4th byte of a word is accepted, state SHALL be WRITE.
REQ-020 WRITE SHALL assert imem_we for exactly one cycle with imem_addr = word counter and imem_wdata = assembled word, then increment the counter; -> DONE if counter+1==N, else -> DATA.
REQ-021 imem_addr and imem_wdata SHALL be stable while imem_we=1; their values are don't-care when imem_we=0.
REQ-022 core_rst SHALL be 1 in every state except DONE; done=1 only in DONE; err=1 only in ERR.
REQ-023 DONE and ERR SHALL be terminal until rst; bytes offered there SHALL be ignored.
REQ-024 s_data SHALL be sampled only on a transfer cycle; s_valid gaps of any length SHALL NOT alter the result except through REQ-025.
REQ-025 With TIMEOUT_CYC>0, an idle counter SHALL clear on each transfer and count cycles without a transfer in DATA, or in HDR after the first header byte; reaching TIMEOUT_CYC -> ERR.
REQ-026 A partially assembled word SHALL never be written to IMEM.
REQ-027 Byte and word counters SHALL be wide enough that N=DEPTH_WORDS completes without wrap; N is compared at full 32-bit width.

Reset
REQ-028 While rst=1 at a rising edge, the state SHALL become HDR and all counters, N and the assembly register SHALL clear; the next cycle SHALL show s_ready=1, imem_we=0, core_rst=1, done=0, err=0.
REQ-029 rst asserted mid-DATA or mid-WRITE SHALL abort the load with no further imem_we; the next image restarts at the header.
REQ-030 rst SHALL have priority over a simultaneous byte transfer.

Verification
REQ-031 N=2, words 0x00500093, 0x00A00113 -> imem_we pulses at addr 0 then 1 with those words; done=1, core_rst=0 the cycle after the 2nd pulse.
REQ-032 N=0 -> DONE one cycle after the 4th header byte; imem_we never asserted.
REQ-033 N=2049 with DEPTH_WORDS=2048 -> err=1, s_ready=0, core_rst=1, no writes.
REQ-034 Image of REQ-031 with random 0-5 cycle s_valid gaps and junk s_data while s_valid=0 -> identical writes and done.
REQ-035 rst pulse after the 6th data byte, then full REQ-031 image -> no write before the restart; final result as REQ-031.
REQ-036 TIMEOUT_CYC=16, stream stalls after 5th byte -> err=1 exactly 16 idle cycles later; no imem_we.
